// File: rtl/heater_pkg.sv
// Shared types and helpers for the heater duty controller and the lfsr_generator bank.
package heater_pkg;

  localparam int unsigned HEATER_FRAME_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP      = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } heater_state_t;

  // Targets above a full frame saturate at 2^frame_w (dv held high).
  function automatic logic [31:0] clamp_duty(input logic [31:0] target,
                                             input int unsigned frame_w);
    logic [31:0] full;
    full = 32'(1) << frame_w;
    return (target > full) ? full : target;
  endfunction

endpackage

// File: rtl/heater_pattern_gen.sv
// Turns the per-frame duty into the registered dv enable stream.
// HEATER_DUTY_DITHER_EN selects a first-order sigma-delta instead of a contiguous burst.
module heater_pattern_gen
  import heater_pkg::*;
#(
  parameter int unsigned FRAME_W = HEATER_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] fcnt,
  input  logic [FRAME_W:0]   duty,
  output logic               dv
);

`ifdef HEATER_DUTY_DITHER_EN
  logic [FRAME_W-1:0] acc;
  logic [FRAME_W-1:0] acc_base;
  logic [FRAME_W:0]   sum;

  // Accumulator restarts every frame so each frame carries exactly duty pulses.
  always_comb begin
    acc_base = (fcnt == '0) ? '0 : acc;
    sum      = {1'b0, acc_base} + duty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      dv  <= 1'b0;
    end else begin
      acc <= sum[FRAME_W-1:0];
      dv  <= sum[FRAME_W];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      dv <= 1'b0;
    end else begin
      dv <= ({1'b0, fcnt} < duty);
    end
  end
`endif

endmodule

// File: rtl/heater_duty_ctrl.sv
// Heater duty controller: frame counter, duty slew FSM and dv pattern for the lfsr_generator lanes.
// Build option: define HEATER_DUTY_DITHER_EN for the sigma-delta dv pattern.
module heater_duty_ctrl
  import heater_pkg::*;
#(
  parameter int unsigned FRAME_W = HEATER_FRAME_W,
  parameter int unsigned RAMP_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_enable,
  input  logic [FRAME_W:0]   cfg_target_duty,
  input  logic [RAMP_W-1:0]  cfg_ramp_frames,
  output logic               dv_out,
  output logic               frame_start,
  output logic [FRAME_W:0]   cur_duty,
  output logic [1:0]         state_out,
  output logic               at_target
);

  localparam int unsigned DUTY_W = FRAME_W + 1;

  heater_state_t       state, state_next;
  logic [FRAME_W-1:0]  fcnt;
  logic [DUTY_W-1:0]   duty, duty_next;
  logic [DUTY_W-1:0]   target_clamped, goal, duty_step;
  logic [RAMP_W-1:0]   rcnt, rcnt_next;
  logic                frame_end;

  assign target_clamped = DUTY_W'(clamp_duty(32'(cfg_target_duty), FRAME_W));
  // Duty and state advance on the last cycle of a frame so the new duty owns the whole next frame.
  assign frame_end      = (state != IDLE) && (fcnt == '1);

  always_comb begin
    state_next = state;
    duty_next  = duty;
    rcnt_next  = rcnt;
    goal       = cfg_enable ? target_clamped : '0;
    duty_step  = (duty < goal) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
    case (state)
      IDLE: begin
        duty_next = '0;
        rcnt_next = '0;
        if (cfg_enable && (target_clamped != '0)) begin
          state_next = RAMP;
        end
      end
      default: begin
        if (frame_end) begin
          if (duty != goal) begin
            if (rcnt == cfg_ramp_frames) begin
              rcnt_next = '0;
              duty_next = duty_step;
            end else begin
              rcnt_next = rcnt + RAMP_W'(1);
            end
          end else begin
            rcnt_next = '0;
          end
          if (!cfg_enable) begin
            state_next = (duty_next == '0) ? IDLE : RAMP_DOWN;
          end else begin
            state_next = (duty_next == target_clamped) ? HOLD : RAMP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fcnt  <= '0;
      duty  <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      duty  <= duty_next;
      rcnt  <= rcnt_next;
      fcnt  <= (state == IDLE) ? '0 : fcnt + FRAME_W'(1);
    end
  end

  // Status outputs share the one-cycle pipeline stage of dv_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
      cur_duty    <= '0;
      state_out   <= 2'd0;
      at_target   <= 1'b0;
    end else begin
      frame_start <= (state != IDLE) && (fcnt == '0);
      cur_duty    <= duty;
      state_out   <= state;
      at_target   <= (state == HOLD);
    end
  end

  heater_pattern_gen #(
    .FRAME_W (FRAME_W)
  ) u_pattern (
    .clk   (clk),
    .reset (reset),
    .fcnt  (fcnt),
    .duty  (duty),
    .dv    (dv_out)
  );

endmodule

// File: tb/tb_heater_duty_ctrl.sv
// Bench for heater_duty_ctrl with 16-cycle frames; a frame-level reference model predicts every output.
module tb_heater_duty_ctrl;

  localparam int unsigned FW   = 4;
  localparam int unsigned RW   = 16;
  localparam int unsigned DW   = FW + 1;
  localparam int unsigned VW   = DW + 5;
  localparam int          FLEN = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [DW-1:0] cfg_target_duty = '0;
  logic [RW-1:0] cfg_ramp_frames = '0;
  logic          dv_out;
  logic          frame_start;
  logic [DW-1:0] cur_duty;
  logic [1:0]    state_out;
  logic          at_target;

  logic [VW-1:0] act_v;
  logic [VW-1:0] exp_v;
  int tests = 0;
  int fails = 0;

  // Reference model: frame position, active flag, duty, step counter and the cfg latched at the last frame end.
  bit m_active, m_en;
  int m_pos, m_duty, m_rcnt, m_tgt;

  heater_duty_ctrl #(.FRAME_W(FW), .RAMP_W(RW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_target_duty (cfg_target_duty),
    .cfg_ramp_frames (cfg_ramp_frames),
    .dv_out          (dv_out),
    .frame_start     (frame_start),
    .cur_duty        (cur_duty),
    .state_out       (state_out),
    .at_target       (at_target)
  );

  always #5 clk = ~clk;

  assign act_v = {dv_out, frame_start, cur_duty, state_out, at_target};

  function automatic int clamp(input int t);
    return (t > FLEN) ? FLEN : t;
  endfunction

  // Whether position pos of a frame at duty d carries a dv pulse.
  function automatic bit pat(input int pos, input int d);
`ifdef HEATER_DUTY_DITHER_EN
    return ((pos + 1) * d / FLEN) != (pos * d / FLEN);
`else
    return pos < d;
`endif
  endfunction

  function automatic int mstate();
    if (!m_active) return 0;
    if (!m_en) return 3;
    if (m_duty == m_tgt) return 2;
    return 1;
  endfunction

  // Predict outputs registered at the coming edge, advance the model, then step the clock.
  task automatic tick();
    int st;
    int goal;
    st = mstate();
    if (reset) exp_v = '0;
    else exp_v = {1'(m_active && pat(m_pos, m_duty)), 1'(m_active && m_pos == 0),
                  DW'(m_duty), 2'(st), 1'(st == 2)};
    if (reset) begin
      m_active = 0; m_en = 0; m_pos = 0; m_duty = 0; m_rcnt = 0; m_tgt = 0;
    end else if (!m_active) begin
      if (cfg_enable && clamp(int'(cfg_target_duty)) != 0) begin
        m_active = 1; m_en = 1; m_pos = 0; m_duty = 0; m_rcnt = 0;
        m_tgt = clamp(int'(cfg_target_duty));
      end
    end else begin
      if (m_pos == FLEN - 1) begin
        goal = cfg_enable ? clamp(int'(cfg_target_duty)) : 0;
        if (m_duty != goal) begin
          if (m_rcnt == int'(cfg_ramp_frames)) begin
            m_rcnt = 0;
            m_duty += (goal > m_duty) ? 1 : -1;
          end else begin
            m_rcnt++;
          end
        end else begin
          m_rcnt = 0;
        end
        m_en  = cfg_enable;
        m_tgt = clamp(int'(cfg_target_duty));
        if (!cfg_enable && m_duty == 0) m_active = 0;
      end
      m_pos = (m_pos + 1) % FLEN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit found;
    reset = 1; cfg_enable = 0; cfg_target_duty = '0; cfg_ramp_frames = '0;
    tick(); tick();
    tests++;
    if (act_v !== '0) begin fails++; $display("FAIL reset_state got %b want 0", act_v); end
    reset = 0; cfg_enable = 1; cfg_target_duty = 5'd8;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL reset_ramp cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start && cur_duty == 5 && state_out == 2'd1) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL reset_reach_duty5 got %0d want 5", cur_duty); end
    tick(); tick(); tick();
    reset = 1;
    tick();
    tests++;
    if ({dv_out, cur_duty, state_out} !== '0) begin
      fails++; $display("FAIL reset_abort got dv=%b duty=%0d st=%0d want 0", dv_out, cur_duty, state_out);
    end
    reset = 0; cfg_enable = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      tests++;
      if (dv_out !== 1'b0 || act_v !== exp_v) begin
        fails++; $display("FAIL reset_idle cyc %0d got %b want %b", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_ramp_up();
    int frames, hi, prev;
    frames = 0; hi = 0; prev = -1;
    cfg_enable = 1; cfg_target_duty = 5'd8; cfg_ramp_frames = '0;
    for (int i = 0; i < 12 * FLEN + 2; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL ramp_up cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start) begin
        if (prev >= 0) begin
          tests++;
          if (hi != prev) begin fails++; $display("FAIL ramp_up_pulses got %0d want %0d", hi, prev); end
        end
        tests++;
        if (int'(cur_duty) != ((frames < 8) ? frames : 8)) begin
          fails++; $display("FAIL ramp_up_duty frame %0d got %0d want %0d", frames, cur_duty, (frames < 8) ? frames : 8);
        end
        tests++;
        if (at_target !== (cur_duty == 5'd8)) begin
          fails++; $display("FAIL ramp_up_at_target got %b want %b", at_target, cur_duty == 5'd8);
        end
        prev = int'(cur_duty); hi = 0; frames++;
      end
      hi += int'(dv_out);
    end
  endtask

  task automatic test_ramp_down();
    int rd_frames, last_duty;
    bit done;
    rd_frames = 0; last_duty = -1; done = 0;
    cfg_ramp_frames = 16'd2;
    tick(); tick();
    cfg_enable = 0;
    for (int i = 0; i < 40 * FLEN && !done; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL ramp_down cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start && state_out == 2'd3) begin rd_frames++; last_duty = int'(cur_duty); end
      if (state_out == 2'd0) done = 1;
    end
    tests++;
    if (!done || rd_frames != 23 || last_duty != 1) begin
      fails++; $display("FAIL ramp_down_frames got %0d frames last %0d want 23 last 1", rd_frames, last_duty);
    end
    for (int i = 0; i < 48; i++) begin
      tick();
      tests++;
      if (dv_out !== 1'b0 || act_v !== exp_v) begin
        fails++; $display("FAIL ramp_down_idle cyc %0d got %b want %b", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_clamp();
    bit found;
    found = 0;
    cfg_enable = 1; cfg_target_duty = 5'd31; cfg_ramp_frames = '0;
    for (int i = 0; i < 25 * FLEN && !found; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL clamp cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start && at_target) found = 1;
    end
    tests++;
    if (!found || cur_duty !== 5'd16) begin fails++; $display("FAIL clamp_hold got %0d want 16", cur_duty); end
    for (int k = 1; k <= 3 * FLEN; k++) begin
      tick();
      tests++;
      if (dv_out !== 1'b1 || cur_duty !== 5'd16 || frame_start !== (k % FLEN == 0)) begin
        fails++; $display("FAIL clamp_full k %0d got dv=%b duty=%0d fs=%b want 1 16 %b", k, dv_out, cur_duty, frame_start, k % FLEN == 0);
      end
    end
  endtask

  task automatic test_retarget();
    bit found;
    found = 0;
    cfg_enable = 0; cfg_ramp_frames = '0;
    for (int i = 0; i < 30 * FLEN && !found; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL retarget_down cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start && state_out == 2'd3 && cur_duty == 5'd5) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL retarget_reach got %0d want 5", cur_duty); end
    for (int i = 0; i < 5; i++) tick();
    cfg_enable = 1; cfg_target_duty = 5'd3;
    for (int f = 0; f < 2; f++) begin
      found = 0;
      for (int i = 0; i < FLEN + 1 && !found; i++) begin
        tick();
        tests++;
        if (act_v !== exp_v) begin fails++; $display("FAIL retarget cyc %0d got %b want %b", i, act_v, exp_v); end
        if (frame_start) found = 1;
        else if (f == 0) begin
          tests++;
          if (cur_duty !== 5'd5) begin fails++; $display("FAIL retarget_midframe got %0d want 5", cur_duty); end
        end
      end
      tests++;
      if (!found || cur_duty !== DW'(4 - f) || state_out !== 2'(1 + f)) begin
        fails++; $display("FAIL retarget_step %0d got duty=%0d st=%0d want %0d %0d", f, cur_duty, state_out, 4 - f, 1 + f);
      end
    end
  endtask

  task automatic test_pattern();
    bit found;
    logic [15:0] mask, want;
`ifdef HEATER_DUTY_DITHER_EN
    want = 16'h8888;
`else
    want = 16'h000F;
`endif
    found = 0;
    cfg_enable = 1; cfg_target_duty = 5'd4; cfg_ramp_frames = '0;
    for (int i = 0; i < 10 * FLEN && !found; i++) begin
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL pattern cyc %0d got %b want %b", i, act_v, exp_v); end
      if (frame_start && at_target && cur_duty == 5'd4) found = 1;
    end
    mask = '0;
    mask[0] = dv_out;
    for (int p = 1; p < FLEN; p++) begin
      tick();
      mask[p] = dv_out;
    end
    tests++;
    if (!found || mask !== want) begin fails++; $display("FAIL pattern_mask got %h want %h", mask, want); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_enable      = ($urandom_range(0, 3) != 0);
        cfg_target_duty = DW'($urandom_range(0, 31));
        cfg_ramp_frames = RW'($urandom_range(0, 2));
      end
      tick();
      tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL random cyc %0d got %b want %b", i, act_v, exp_v); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_retarget();
    test_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
